// File: rtl/run_sequencer_pkg.sv
// Definitions: shared types and constants for the run sequencer.
// Contents: seq_state_t (FSM encoding) and HALT_WORD (the all-ones stop instruction).
// No ports; imported by run_sequencer.
package Definitions;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEMWAIT,
    WB,
    DONE
  } seq_state_t;

  // Instruction word that ends a run; the decoder flags it on DecHalt.
  localparam logic [8:0] HALT_WORD = 9'h1FF;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// Ports: i_clk, i_rst_n (async active-low), i_clr (sync clear, wins over inc),
//        i_inc (count enable), o_val (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_val
);

  logic [W-1:0] r_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val <= '0;
    end else if (i_clr) begin
      r_val <= '0;
    end else if (i_inc && (r_val != '1)) begin
      r_val <= r_val + W'(1);
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: multi-cycle run controller for the 9-bit core.
// Steps each instruction through FETCH/EXEC/(MEMWAIT)/WB, gates decoder enables into
// single-cycle strobes, stops on halt or cycle-budget timeout, counts cycles/instructions.
// Ports: Clk, Reset (async active-low), Start (run request level);
//        DecRegWrEn/DecMemWrEn/DecLoad/DecHalt (decoder flags for the current instruction);
//        PcInit/PcEn/IrLoad/RegWrStb/MemWrStb (strobes), Busy, Done, Timeout,
//        CycleCount/InstrCount (saturating).
module run_sequencer
  import Definitions::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 65535
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             DecRegWrEn,
  input  logic             DecMemWrEn,
  input  logic             DecLoad,
  input  logic             DecHalt,
  output logic             PcInit,
  output logic             PcEn,
  output logic             IrLoad,
  output logic             RegWrStb,
  output logic             MemWrStb,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  // Wait counter preload: MEM_LAT MEMWAIT visits means preload MEM_LAT-1 and leave at 0.
  localparam logic [2:0]       WAIT_INIT = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;
  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(MAX_CYCLES - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [2:0]       r_wait;
  logic             r_timeout;

  logic             w_busy;
  logic             w_budget;
  logic             w_pc_init;
  logic             w_pc_en;
  logic             w_ir_load;
  logic             w_reg_wr;
  logic             w_mem_wr;
  logic             w_cnt_clr;
  logic             w_instr_inc;
  logic             w_wait_ld;
  logic             w_set_to;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] w_instr_cnt;

  assign w_busy   = (r_state != IDLE) && (r_state != DONE);
  // Last budgeted cycle: this cycle's work is abandoned and the run ends.
  assign w_budget = w_busy && (w_cycle_cnt == LAST_CYC);

  always_comb begin
    w_next      = r_state;
    w_pc_init   = 1'b0;
    w_pc_en     = 1'b0;
    w_ir_load   = 1'b0;
    w_reg_wr    = 1'b0;
    w_mem_wr    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_instr_inc = 1'b0;
    w_wait_ld   = 1'b0;
    w_set_to    = 1'b0;

    case (r_state)
      IDLE: begin
        if (Start) begin
          w_pc_init = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = FETCH;
        end
      end
      FETCH: begin
        w_ir_load = 1'b1;
        w_next    = EXEC;
      end
      EXEC: begin
        if (DecHalt) begin
          w_next = DONE;
        end else begin
          // Store strobe issued once here, not in MEMWAIT, so each sw writes exactly once.
          w_mem_wr = DecMemWrEn;
          if ((DecLoad || DecMemWrEn) && (MEM_LAT > 0)) begin
            w_wait_ld = 1'b1;
            w_next    = MEMWAIT;
          end else begin
            w_next = WB;
          end
        end
      end
      MEMWAIT: begin
        if (r_wait == 3'd0) begin
          w_next = WB;
        end
      end
      WB: begin
        w_reg_wr    = DecRegWrEn;
        w_pc_en     = 1'b1;
        w_instr_inc = 1'b1;
        w_next      = FETCH;
      end
      DONE: begin
        // A level-held Start must drop before another run can begin.
        if (!Start) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // Budget expiry overrides halt, writeback and every strobe.
    if (w_budget) begin
      w_pc_en     = 1'b0;
      w_ir_load   = 1'b0;
      w_reg_wr    = 1'b0;
      w_mem_wr    = 1'b0;
      w_instr_inc = 1'b0;
      w_wait_ld   = 1'b0;
      w_set_to    = 1'b1;
      w_next      = DONE;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_wait    <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wait_ld) begin
        r_wait <= WAIT_INIT;
      end else if ((r_state == MEMWAIT) && (r_wait != 3'd0)) begin
        r_wait <= r_wait - 3'd1;
      end
      if (w_cnt_clr) begin
        r_timeout <= 1'b0;
      end else if (w_set_to) begin
        r_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_busy),
    .o_val   (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_instr_inc),
    .o_val   (w_instr_cnt)
  );

  // PcInit is the only strobe fed straight from an input while in IDLE, so it is
  // masked by Reset to keep every output low for the whole reset interval.
  assign PcInit     = w_pc_init & Reset;
  assign PcEn       = w_pc_en;
  assign IrLoad     = w_ir_load;
  assign RegWrStb   = w_reg_wr;
  assign MemWrStb   = w_mem_wr;
  assign Busy       = w_busy;
  assign Done       = (r_state == DONE);
  assign Timeout    = r_timeout && (r_state == DONE);
  assign CycleCount = w_cycle_cnt;
  assign InstrCount = w_instr_cnt;

endmodule
